// File: rtl/clock_set_controller_if.sv
// ---------------------------------------------------------------------------
// clock_set_controller_if
// Purpose : bundles the time-set controller's button/tick inputs and its
//           datapath/display outputs into one connection.
// Signals : tick_1hz            1 Hz load strobe (clk domain, one cycle)
//           btn_mode/inc/dec    raw pushbuttons, active-high, asynchronous
//           cur_time[23:0]      current BCD time {hh,mm,ss}
//           value_set_register  BCD pair {tens,units} toward the datapath
//           value_set_selection 00 run, 10 hours, 01 minutes, 11 seconds
//           edit_field[2:0]     one-hot {hour,min,sec} under edit
//           blink_on            display-blank phase for the edited field
// Modports: master = side that drives buttons/tick/time (board/datapath)
//           slave  = the controller itself
// ---------------------------------------------------------------------------
interface clock_set_controller_if;
  logic        tick_1hz;
  logic        btn_mode;
  logic        btn_inc;
  logic        btn_dec;
  logic [23:0] cur_time;
  logic [7:0]  value_set_register;
  logic [1:0]  value_set_selection;
  logic [2:0]  edit_field;
  logic        blink_on;

  modport master (
    output tick_1hz, btn_mode, btn_inc, btn_dec, cur_time,
    input  value_set_register, value_set_selection, edit_field, blink_on
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, btn_dec, cur_time,
    output value_set_register, value_set_selection, edit_field, blink_on
  );
endinterface

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
// Purpose : button-driven time-set sequencer. Debounces mode/inc/dec, walks
//           hours -> minutes -> seconds, drives the datapath's value/selection
//           pair and holds each selection until a 1 Hz load edge has passed.
// Ports   : clk  system clock
//           rst  asynchronous active-low reset
//           bus  clock_set_controller_if.slave (buttons, tick, time, outputs)
// Options : define AUTOREPEAT_EN to make held inc/dec auto-repeat after
//           REPEAT_DELAY cycles, then every REPEAT_CYCLES cycles.
// ---------------------------------------------------------------------------
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_TICKS   = 10,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_set_controller_if.slave bus
);

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("clock_set_controller: parameter out of range");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_RUN, S_HOUR, S_HOUR_W, S_MIN, S_MIN_W, S_SEC, S_SEC_W
  } state_t;

  // Bit 2 = mode, bit 1 = inc, bit 0 = dec
  logic [2:0]    sync1_q, sync2_q, lvl_q, press_q;
  logic [CW-1:0] cnt_q [3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {bus.btn_mode, bus.btn_inc, bus.btn_dec};
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        // Count consecutive samples that disagree with the accepted level;
        // the DEBOUNCE_CYCLES-th one flips it.
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          cnt_q[i]   <= '0;
          lvl_q[i]   <= sync2_q[i];
          press_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic p_mode, p_inc, p_dec;
  assign p_mode = press_q[2];

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYCLES - 1);

  // Index 1 = inc, index 0 = dec (same as the debouncer)
  logic [1:0]    rep_q, first_q;
  logic [RW-1:0] rcnt_q [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q   <= '0;
      first_q <= '1;
      for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_q[i] <= 1'b0;
        if (!lvl_q[i] || press_q[i]) begin
          rcnt_q[i]  <= '0;
          first_q[i] <= 1'b1;
        end else if (rcnt_q[i] == (first_q[i] ? RD_LAST : RC_LAST)) begin
          rcnt_q[i]  <= '0;
          first_q[i] <= 1'b0;
          rep_q[i]   <= 1'b1;
        end else begin
          rcnt_q[i] <= rcnt_q[i] + RW'(1);
        end
      end
    end
  end

  assign p_inc = press_q[1] | rep_q[1];
  assign p_dec = press_q[0] | rep_q[0];
`else
  assign p_inc = press_q[1];
  assign p_dec = press_q[0];
`endif

  function automatic logic [7:0] clamp_hour(input logic [7:0] v);
    if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] > 4'd3)) return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] clamp_ms(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec_hour(input logic [7:0] v);
    if (v == 8'h00) return 8'h23;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] inc_ms(input logic [7:0] v);
    if (v == 8'h59) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec_ms(input logic [7:0] v);
    if (v == 8'h00) return 8'h59;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    buf_q, buf_d;
  logic [TW-1:0] to_q, to_d;
  logic          blink_q, blink_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      buf_q   <= 8'h00;
      to_q    <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      to_q    <= to_d;
      blink_q <= blink_d;
    end
  end

  logic edit_inc, edit_dec, any_press;
  // Mode overrides edits; inc together with dec cancels both.
  assign edit_inc  = p_inc & ~p_dec & ~p_mode;
  assign edit_dec  = p_dec & ~p_inc & ~p_mode;
  assign any_press = p_mode | p_inc | p_dec;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    to_d    = to_q;
    blink_d = blink_q;
    unique case (state_q)
      S_RUN: begin
        if (p_mode) begin
          state_d = S_HOUR;
          buf_d   = clamp_hour(bus.cur_time[23:16]);
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (p_mode) begin
          state_d = (state_q == S_HOUR) ? S_HOUR_W :
                    (state_q == S_MIN)  ? S_MIN_W  : S_SEC_W;
        end else if (edit_inc) begin
          buf_d = (state_q == S_HOUR) ? inc_hour(buf_q) : inc_ms(buf_q);
        end else if (edit_dec) begin
          buf_d = (state_q == S_HOUR) ? dec_hour(buf_q) : dec_ms(buf_q);
        end
        if (any_press) begin
          to_d = '0;
        end else if (bus.tick_1hz) begin
          if (to_q == TO_LAST) begin
            // Finish through SEC_W; seconds are rewritten with their own
            // current value so an abandoned hour/min edit never lands there.
            state_d = S_SEC_W;
            if (state_q != S_SEC) buf_d = clamp_ms(bus.cur_time[7:0]);
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end
      S_HOUR_W: begin
        if (bus.tick_1hz) begin
          state_d = S_MIN;
          buf_d   = clamp_ms(bus.cur_time[15:8]);
        end
      end
      S_MIN_W: begin
        if (bus.tick_1hz) begin
          state_d = S_SEC;
          buf_d   = clamp_ms(bus.cur_time[7:0]);
        end
      end
      S_SEC_W: begin
        if (bus.tick_1hz) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (state_d != state_q) to_d = '0;
    if (state_d == S_RUN) blink_d = 1'b0;
    else if (bus.tick_1hz && state_q != S_RUN) blink_d = ~blink_q;
  end

  always_comb begin
    bus.value_set_selection = 2'b00;
    bus.edit_field          = 3'b000;
    bus.value_set_register  = 8'h00;
    unique case (state_q)
      S_HOUR, S_HOUR_W: begin bus.value_set_selection = 2'b10; bus.edit_field = 3'b100; end
      S_MIN,  S_MIN_W:  begin bus.value_set_selection = 2'b01; bus.edit_field = 3'b010; end
      S_SEC,  S_SEC_W:  begin bus.value_set_selection = 2'b11; bus.edit_field = 3'b001; end
      default: ;
    endcase
    if (state_q != S_RUN) bus.value_set_register = buf_q;
  end

  assign bus.blink_on = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller (DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3).
// Output tuple {selection, value, edit_field, blink}; the monitor compares on
// every change of the tuple, or when the stimulus requests a snapshot.
module tb_clock_set_controller;
  localparam int DB = 4;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  clock_set_controller_if bus();

  clock_set_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] v;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          snap_req = 0;
  int          snap_ack = 0;
  bit          mon_en = 1'b0;
  logic [13:0] prev = '0;
  logic [7:0]  inc_seq [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

  function automatic logic [13:0] tup(input logic [1:0] s, input logic [7:0] v,
                                      input logic [2:0] f, input logic b);
    return {s, v, f, b};
  endfunction

  task automatic push(input logic [13:0] v, input int c, input string nm);
    exp_t e;
    e.v = v; e.cyc = c; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per observed output event.
  always @(negedge clk) begin
    logic [13:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {bus.value_set_selection, bus.value_set_register, bus.edit_field, bus.blink_on};
      if (cur !== prev || snap_req != snap_ack) begin
        snap_ack = snap_req;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change actual=%h required=no_change", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc))
          begin
            errors++;
            $display("FAIL %s actual=%h at cyc %0d required=%h at cyc %0d",
                     e.nm, cur, cyc, e.v, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic snap(input logic [13:0] v, input string nm);
    @(posedge clk); #1;
    push(v, -1, nm);
    snap_req++;
    @(posedge clk); #1;
  endtask

  // Raise the given buttons for 'hold' cycles; optional tick aligned with
  // the cycle the FSM sees the press. 'lat' pins the output change to 7
  // cycles after the raw edge (2 sync + 4 debounce + pulse + FSM update).
  task automatic press(input logic m, input logic i, input logic d, input int hold,
                       input bit tk, input bit has, input logic [13:0] ev,
                       input bit lat, input string nm);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    if (has) push(ev, lat ? c0 + 7 : -1, nm);
    bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d;
    for (int k = 1; k <= hold + 10; k++) begin
      @(posedge clk); #1;
      if (k == hold) begin
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
      end
      if (tk && k == 6) bus.tick_1hz = 1'b1;
      if (tk && k == 7) bus.tick_1hz = 1'b0;
    end
  endtask

  task automatic btn(input logic m, input logic i, input logic d,
                     input logic [13:0] ev, input string nm);
    press(m, i, d, 6, 1'b0, 1'b1, ev, 1'b0, nm);
  endtask

  task automatic tick_exp(input logic [13:0] ev, input string nm);
    push(ev, -1, nm);
    @(posedge clk); #1; bus.tick_1hz = 1'b1;
    @(posedge clk); #1; bus.tick_1hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    bus.cur_time = 24'h234510;
    #2 rst = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(tup(2'b00, 8'h00, 3'b000, 1'b0), -1, "reset_outputs");
    snap_req++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Entry, debounce latency, glitch rejection, hour wrap
    press(1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b1, tup(2'b10, 8'h23, 3'b100, 1'b0), 1'b1, "mode_enter_hour_latency");
    press(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, '0, 1'b0, "");
    press(1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b1, tup(2'b10, 8'h00, 3'b100, 1'b0), 1'b1, "inc_hour_wrap_latency");
    btn(1'b0, 1'b0, 1'b1, tup(2'b10, 8'h23, 3'b100, 1'b0), "dec_hour_wrap");
    btn(1'b0, 1'b0, 1'b1, tup(2'b10, 8'h22, 3'b100, 1'b0), "dec_hour");

    // mode+inc together: wait state, buffer unchanged
    press(1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0, '0, 1'b0, "");
    snap(tup(2'b10, 8'h22, 3'b100, 1'b0), "mode_inc_same_cycle");
    bus.cur_time = 24'h237A10;
    tick_exp(tup(2'b01, 8'h00, 3'b010, 1'b1), "hourw_tick_to_min_clamp");

    // Minutes: inc+dec cancel, wraps, BCD carries
    press(1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b0, '0, 1'b0, "");
    snap(tup(2'b01, 8'h00, 3'b010, 1'b1), "inc_dec_same_cycle");
    btn(1'b0, 1'b0, 1'b1, tup(2'b01, 8'h59, 3'b010, 1'b1), "dec_min_wrap");
    btn(1'b0, 1'b1, 1'b0, tup(2'b01, 8'h00, 3'b010, 1'b1), "inc_min_wrap");
    for (int k = 0; k < 10; k++)
      btn(1'b0, 1'b1, 1'b0, tup(2'b01, inc_seq[k], 3'b010, 1'b1), "inc_min_seq");
    btn(1'b0, 1'b0, 1'b1, tup(2'b01, 8'h09, 3'b010, 1'b1), "dec_min_10_to_09");

    // mode coincident with tick must still wait for the next tick
    press(1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b1, tup(2'b01, 8'h09, 3'b010, 1'b0), 1'b0, "mode_tick_same_cycle_waits");
    bus.cur_time = 24'h120437;
    repeat (5) @(posedge clk);
    #1;
    tick_exp(tup(2'b11, 8'h37, 3'b001, 1'b1), "minw_tick_to_sec");
    press(1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0, '0, 1'b0, "");
    snap(tup(2'b11, 8'h37, 3'b001, 1'b1), "secw_holds");
    tick_exp(tup(2'b00, 8'h00, 3'b000, 1'b0), "secw_tick_to_run");

    // Timeout after 3 idle ticks in HOUR
    btn(1'b1, 1'b0, 1'b0, tup(2'b10, 8'h12, 3'b100, 1'b0), "enter_hour_for_timeout");
    tick_exp(tup(2'b10, 8'h12, 3'b100, 1'b1), "timeout_tick1");
    tick_exp(tup(2'b10, 8'h12, 3'b100, 1'b0), "timeout_tick2");
    tick_exp(tup(2'b11, 8'h37, 3'b001, 1'b1), "timeout_to_secw");
    tick_exp(tup(2'b00, 8'h00, 3'b000, 1'b0), "timeout_secw_to_run");

    // Asynchronous reset in the middle of an edit
    btn(1'b1, 1'b0, 1'b0, tup(2'b10, 8'h12, 3'b100, 1'b0), "enter_hour_before_reset");
    @(posedge clk); #1;
    push(tup(2'b00, 8'h00, 3'b000, 1'b0), cyc, "async_reset_mid_edit");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Out-of-range hour loads as 00
    bus.cur_time = 24'h275959;
    btn(1'b1, 1'b0, 1'b0, tup(2'b10, 8'h00, 3'b100, 1'b0), "hour_clamp_on_load");

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Button-driven time-set sequencer for the digital clock datapath. Debounces mode/inc/dec pushbuttons and walks hours → minutes → seconds. Drives the datapath's value_set_register / value_set_selection pair and holds each selection until a 1 Hz load edge has occurred, so the datapath always captures the final edited value. Also provides field/blink hints for the display mux.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable clk cycles before a button level is accepted (≥2)
TIMEOUT_TICKS, 10, 1 Hz ticks with no accepted press before edit auto-exits (≥1)
REPEAT_DELAY, 1000, clk cycles held before first auto-repeat (AUTOREPEAT_EN only)
REPEAT_CYCLES, 250, clk cycles between auto-repeats (AUTOREPEAT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
tick_1hz  in  1  single-cycle clk-domain strobe coincident with datapath 1 Hz load edge
btn_mode  in  1  raw mode button, active-high, asynchronous
btn_inc  in  1  raw increment button, active-high, asynchronous
btn_dec  in  1  raw decrement button, active-high, asynchronous
cur_time  in  24  current BCD time {hour_l,hour_r,min_l,min_r,sec_l,sec_r}
value_set_register  out  8  BCD pair {tens,units} to datapath
value_set_selection  out  2  00 run, 10 hours, 01 minutes, 11 seconds
edit_field  out  3  one-hot {hour,min,sec} field under edit, 000 in RUN
blink_on  out  1  display-blank phase for the edited field

Behaviour:
- Reset (rst low, async): state RUN, all outputs 0, edit buffer 00, debouncers cleared to "released", timeout counter 0.
- Button path: 2-FF synchronizer, then debouncer. Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples. Accepted 0→1 produces a one-cycle press pulse. Latency from stable raw edge to pulse: 2+DEBOUNCE_CYCLES clk.
- States: RUN, HOUR, HOUR_W, MIN, MIN_W, SEC, SEC_W.
- RUN: selection 00. mode press → HOUR; buffer loads cur_time[23:16].
- HOUR/MIN/SEC: selection 10/01/11, value_set_register = buffer, edit_field one-hot. inc/dec press edits buffer. mode press → corresponding _W.
- X_W: selection and value unchanged. On tick_1hz → next state: HOUR_W→MIN (load cur_time[15:8]), MIN_W→SEC (load [7:0]), SEC_W→RUN. Button presses in _W are ignored.
- Load clamp: loaded pair with tens>2 or hour>23 (hours), or tens>5 or units>9 (min/sec), loads as 00.
- BCD arithmetic, hours: inc 23→00, 09→10, 19→20; dec 00→23, 10→09.
- BCD arithmetic, min/sec: inc 59→00, x9→(x+1)0; dec 00→59, x0→(x-1)9.
- Buffer never holds a non-BCD or out-of-range value.
- Simultaneous events: mode with inc/dec in the same cycle → mode wins, edit dropped. inc and dec in the same cycle → both ignored. tick_1hz in the same cycle as a mode press in HOUR/MIN/SEC → enter _W; do not skip the wait.
- Timeout: counter clears on any accepted press and on state entry, and increments on tick_1hz in HOUR/MIN/SEC. At TIMEOUT_TICKS → SEC_W (the current field is already loaded each tick; return to RUN after the next tick).
- blink_on: toggles on each tick_1hz while edit_field≠0. Forced 0 in RUN.
- Reset mid-edit: immediate RUN, selection 00. Datapath keeps whatever it last loaded.

Optional Feature:
AUTOREPEAT_EN defined: inc/dec held accepted-high generates an extra press after REPEAT_DELAY cycles, then every REPEAT_CYCLES cycles until release. Repeats reset the timeout.
Not defined: exactly one press per accepted 0→1 edge; REPEAT_* parameters unused.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3.)
- Reset/debounce: rst low → all outputs 0. btn_inc glitch of 3 clk high → no press. Clean press of 6 clk → one pulse 6 clk after the raw edge.
- Hour wrap: cur_time=23:45:10, mode → selection 10, value 0x23. inc → 0x00. dec ×2 → 0x22.
- Field sequencing: in MIN with value 0x59, inc → 0x00. mode → selection holds 01 until tick_1hz, then 11 with value = cur_time sec.
- Clamp/BCD: cur_time min field 0x7A on entry → value 0x00. inc from 0x09 → 0x10. dec from 0x10 → 0x09.
- Simultaneous: mode+inc same cycle in HOUR → HOUR_W, buffer unchanged. inc+dec same cycle → no change.
- Timeout/reset: no presses for 3 ticks in HOUR → SEC_W, then RUN after 1 tick. rst pulse mid-edit → selection 00 immediately. With AUTOREPEAT_EN, inc held REPEAT_DELAY+2·REPEAT_CYCLES → buffer +3.
